led_shift_out: RTL and testbench

Serializer stage directly downstream of the LED counter. It watches the parallel LED word and, whenever the value differs from the last one transmitted, shifts it out MSB-first to an external 74HC595-style shift register chain and pulses a latch. A full refresh is always sent after reset, so the external chain matches the counter's reset value of 0.

---
 rtl/led_pkg.sv | 17 +
 rtl/led_shift_tick.sv | 32 +++
 rtl/led_shift_out.sv | 142 ++++++++++++++
 tb/tb_led_shift_out.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
// Shared definitions for the LED counter / serializer family.
//   shift_state_t : serializer FSM state encoding
//   LED_WIDTH     : default LED word width
//   LED_CLKDIV    : default CLK cycles per SCLK half-period
package led_pkg;

  localparam int LED_WIDTH  = 8;
  localparam int LED_CLKDIV = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOW    = 2'd1,
    HIGH   = 2'd2,
    STROBE = 2'd3
  } shift_state_t;

endpackage

// File: rtl/led_shift_tick.sv
// Phase timer for the LED serializer: counts CLKDIV cycles per phase.
//   CLK        : system clock
//   RST        : synchronous active-high reset
//   restart    : hold the count at 0 (used while the serializer is idle)
//   phase_done : high on the last cycle of a CLKDIV-cycle phase
module led_shift_tick
  import led_pkg::*;
#(
  parameter int CLKDIV = LED_CLKDIV
) (
  input  logic CLK,
  input  logic RST,
  input  logic restart,
  output logic phase_done
);

  // One bit minimum so CLKDIV=1 still yields a legal vector.
  localparam int DW = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
  localparam logic [DW-1:0] LAST = DW'(CLKDIV - 1);

  logic [DW-1:0] divcnt;

  // Wrapping on phase_done means every phase starts from 0 without
  // the FSM having to request a restart at each transition.
  always_ff @(posedge CLK) begin
    if (RST || restart || phase_done) divcnt <= '0;
    else                              divcnt <= divcnt + DW'(1);
  end

  assign phase_done = (divcnt == LAST);

endmodule

// File: rtl/led_shift_out.sv
// LED word serializer for a 74HC595-style chain. Whenever LED_IN differs
// from the last word sent (or after reset), shifts it out on SCLK/SDATA
// and strobes LATCH.
//   CLK    : system clock, rising edge
//   RST    : synchronous active-high reset
//   LED_IN : parallel LED word, sampled only while idle
//   SCLK   : serial clock, idles low
//   SDATA  : serial data, changes only while SCLK is low
//   LATCH  : storage strobe, CLKDIV cycles wide
//   BUSY   : high for the whole transfer including the latch phase
//   DONE   : one-cycle pulse in the first cycle after BUSY falls
module led_shift_out
  import led_pkg::*;
#(
  parameter int WIDTH     = LED_WIDTH,
  parameter int CLKDIV    = LED_CLKDIV,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] LED_IN,
  output logic             SCLK,
  output logic             SDATA,
  output logic             LATCH,
  output logic             BUSY,
  output logic             DONE
);

  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

  shift_state_t     state, state_n;
  logic [WIDTH-1:0] shreg, shreg_n;
  logic [WIDTH-1:0] last, last_n;
  logic [BW-1:0]    bitcnt, bitcnt_n;
  logic             init_pend, init_pend_n;
  logic             sclk_n, sdata_n, latch_n, busy_n, done_n;
  logic             phase_done;

  function automatic logic lead_bit(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  function automatic logic [WIDTH-1:0] shift_word(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? (w << 1) : (w >> 1);
  endfunction

  led_shift_tick #(.CLKDIV(CLKDIV)) u_tick (
    .CLK       (CLK),
    .RST       (RST),
    .restart   (state == IDLE),
    .phase_done(phase_done)
  );

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the case statement can leave a signal unassigned (latch).
    state_n     = state;
    shreg_n     = shreg;
    last_n      = last;
    bitcnt_n    = bitcnt;
    init_pend_n = init_pend;
    sclk_n      = SCLK;
    sdata_n     = SDATA;
    latch_n     = LATCH;
    busy_n      = BUSY;
    done_n      = 1'b0;

    unique case (state)
      IDLE: begin
        if (init_pend || (LED_IN != last)) begin
          shreg_n     = LED_IN;
          last_n      = LED_IN;
          init_pend_n = 1'b0;
          bitcnt_n    = '0;
          sdata_n     = lead_bit(LED_IN);
          busy_n      = 1'b1;
          state_n     = LOW;
        end
      end
      LOW: begin
        if (phase_done) begin
          sclk_n  = 1'b1;
          state_n = HIGH;
        end
      end
      HIGH: begin
        if (phase_done) begin
          sclk_n = 1'b0;
          if (bitcnt != LAST_BIT) begin
            shreg_n  = shift_word(shreg);
            sdata_n  = lead_bit(shift_word(shreg));
            bitcnt_n = bitcnt + BW'(1);
            state_n  = LOW;
          end else begin
            sdata_n = 1'b0;
            latch_n = 1'b1;
            state_n = STROBE;
          end
        end
      end
      STROBE: begin
        if (phase_done) begin
          latch_n = 1'b0;
          busy_n  = 1'b0;
          done_n  = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // NOTE: reset is synchronous here, so it sits inside the clocked branch
  // rather than in the sensitivity list; all state uses non-blocking <=.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      shreg     <= '0;
      last      <= '0;
      bitcnt    <= '0;
      init_pend <= 1'b1;
      SCLK      <= 1'b0;
      SDATA     <= 1'b0;
      LATCH     <= 1'b0;
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
    end else begin
      state     <= state_n;
      shreg     <= shreg_n;
      last      <= last_n;
      bitcnt    <= bitcnt_n;
      init_pend <= init_pend_n;
      SCLK      <= sclk_n;
      SDATA     <= sdata_n;
      LATCH     <= latch_n;
      BUSY      <= busy_n;
      DONE      <= done_n;
    end
  end

endmodule

// File: tb/tb_led_shift_out.sv
// Bench for led_shift_out: two instances (CLKDIV=2 MSB-first, CLKDIV=1
// LSB-first). A negedge monitor records the bit seen at every SCLK rise;
// each transfer is rebuilt into a word and compared with the word the
// bench expects, along with BUSY/LATCH lengths, DONE and start latency.
module tb_led_shift_out;

  localparam int W = 8;
  localparam int CDIV [2] = '{2, 1};
  localparam bit MSBF [2] = '{1'b1, 1'b0};

  logic         clk;
  logic [1:0]   rst;
  logic [W-1:0] led [2];
  logic [1:0]   sclk, sdata, latch, busy, done;

  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;

  logic [1:0] sclk_q = '0;
  logic       cap [2][1024];
  int         nbits [2] = '{0, 0};
  int         act [2] = '{0, 0};

  led_shift_out #(.WIDTH(W), .CLKDIV(2), .MSB_FIRST(1'b1)) dut0 (
    .CLK(clk), .RST(rst[0]), .LED_IN(led[0]), .SCLK(sclk[0]),
    .SDATA(sdata[0]), .LATCH(latch[0]), .BUSY(busy[0]), .DONE(done[0])
  );

  led_shift_out #(.WIDTH(W), .CLKDIV(1), .MSB_FIRST(1'b0)) dut1 (
    .CLK(clk), .RST(rst[1]), .LED_IN(led[1]), .SCLK(sclk[1]),
    .SDATA(sdata[1]), .LATCH(latch[1]), .BUSY(busy[1]), .DONE(done[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (sclk[d] && !sclk_q[d] && nbits[d] < 1024) begin
        cap[d][nbits[d]] <= sdata[d];
        nbits[d]         <= nbits[d] + 1;
      end
      if (sclk[d] | latch[d] | busy[d] | done[d]) act[d] <= act[d] + 1;
    end
    sclk_q <= sclk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full transfer on DUT d expected to carry 'word'. t0 is the cycle the
  // triggering input changed (negative: latency not checked).
  task automatic xfer(input int d, input logic [W-1:0] word, input int t0,
                      input string tag, output int base);
    int guard, nb, nl;
    logic [W-1:0] got;
    base  = nbits[d];
    guard = 0;
    while (busy[d] !== 1'b1 && guard < 100) begin
      step();
      guard++;
    end
    check({tag, "_start"}, busy[d], 1);
    if (t0 >= 0) check({tag, "_latency"}, cyc - t0, 1);
    nb = 0;
    nl = 0;
    guard = 0;
    while (busy[d] === 1'b1 && guard < 200) begin
      nb++;
      if (latch[d] === 1'b1) nl++;
      step();
      guard++;
    end
    check({tag, "_busy_len"}, nb, 2 * W * CDIV[d] + CDIV[d]);
    check({tag, "_latch_len"}, nl, CDIV[d]);
    check({tag, "_done"}, done[d], 1);
    check({tag, "_nbits"}, nbits[d] - base, W);
    got = '0;
    for (int i = 0; i < W; i++)
      got[MSBF[d] ? (W - 1 - i) : i] = cap[d][base + i];
    check({tag, "_word"}, got, word);
    step();
    check({tag, "_done_once"}, done[d], 0);
  endtask

  initial begin
    int t0, b, a0, guard;
    logic [W-1:0] v, cur;

    rst    = 2'b11;
    led[0] = 8'h00;
    led[1] = 8'h80;
    repeat (3) step();
    check("reset_out0", {sclk[0], sdata[0], latch[0], busy[0], done[0]}, 0);
    check("reset_out1", {sclk[1], sdata[1], latch[1], busy[1], done[1]}, 0);

    // Refresh after reset release with LED_IN=0.
    rst[0] = 1'b0;
    t0 = cyc;
    xfer(0, 8'h00, t0, "rst_release", b);

    // Value change 0x00 -> 0xA5.
    repeat (3) step();
    led[0] = 8'hA5;
    t0 = cyc;
    xfer(0, 8'hA5, t0, "chg_a5", b);

    // Steady input: no activity.
    a0 = act[0];
    repeat (500) step();
    check("steady_quiet", act[0] - a0, 0);

    // Changes during a transfer: only the latest value follows.
    led[0] = 8'h01;
    t0 = cyc;
    fork
      xfer(0, 8'h01, t0, "mid_01", b);
      begin
        repeat (5) step();
        led[0] = 8'h02;
        repeat (10) step();
        led[0] = 8'h03;
      end
    join
    xfer(0, 8'h03, -1, "mid_03", b);
    a0 = act[0];
    repeat (100) step();
    check("mid_no_more", act[0] - a0, 0);

    // Random words with random idle gaps.
    cur = 8'h03;
    repeat (4) begin
      do v = W'($urandom_range(0, 255)); while (v == cur || v == 8'hFF);
      repeat ($urandom_range(1, 5)) step();
      led[0] = v;
      t0 = cyc;
      xfer(0, v, t0, "rand0", b);
      cur = v;
    end

    // Reset during bit 3 of a 0xFF transfer.
    led[0] = 8'hFF;
    b = nbits[0];
    guard = 0;
    while (nbits[0] - b < 3 && guard < 100) begin
      step();
      guard++;
    end
    check("rst_mid_reached", nbits[0] - b, 3);
    rst[0] = 1'b1;
    step();
    check("rst_mid_out", {sclk[0], sdata[0], latch[0], busy[0], done[0]}, 0);
    rst[0] = 1'b0;
    t0 = cyc;
    xfer(0, 8'hFF, t0, "rst_mid_refresh", b);

    // Second instance: CLKDIV=1, LSB first, LED_IN=0x80.
    rst[1] = 1'b0;
    t0 = cyc;
    xfer(1, 8'h80, t0, "p_sweep", b);
    check("p_sweep_last_bit", cap[1][b + 7], 1);
    for (int i = 0; i < 7; i++) check("p_sweep_early_bit", cap[1][b + i], 0);

    cur = 8'h80;
    repeat (3) begin
      do v = W'($urandom_range(0, 255)); while (v == cur);
      repeat ($urandom_range(1, 4)) step();
      led[1] = v;
      t0 = cyc;
      xfer(1, v, t0, "rand1", b);
      cur = v;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
